avalon_multichannel_timer: RTL and testbench
============================================

// Module: avalon_multichannel_timer
// PURPOSE
//  Parametrised N-channel interval timer; Avalon-MM slave, DATA_W-bit bus, one IRQ per channel plus OR'd irq.
//  Each channel: CNT_W-bit down-counter, programmable prescaler, one-shot/continuous modes, counter snapshot.
//  Drop-in successor to the single-channel system timer in the Qsys system; sits on the CPU data master.
// PARAMETERS
//  NUM_CH       4      channels, 1..8
//  DATA_W       16     Avalon data width
//  CNT_W        32     counter width; DATA_W < CNT_W <= 2*DATA_W
//  PRESCALE_W   8      prescaler width
//  RESET_PERIOD 49999  period and counter value after reset (all channels)
// PORTS
//  clk         in   1                          clock
//  reset_n     in   1                          reset, asynchronous, active-low
//  chipselect  in   1                          Avalon select
//  write_n     in   1                          Avalon write, active-low
//  address     in   $clog2(NUM_CH)+3           {channel, reg[2:0]}
//  writedata   in   DATA_W                     write data
//  readdata    out  DATA_W                     registered read data
//  irq_vec     out  NUM_CH                     per-channel interrupt
//  irq         out  1                          OR of irq_vec
// BEHAVIOUR
//  Reg map (per channel): 0 STATUS{run,to} wr=clear to; 1 CONTROL{stop,start,cont,ito} bits[3:0];
//   2 PERIOD_L; 3 PERIOD_H (bits above CNT_W-DATA_W ignored, read 0); 4 SNAP_L (any write = take snapshot);
//   5 SNAP_H; 6 PRESCALE [PRESCALE_W-1:0]; 7 reserved, reads 0, writes ignored. Channel index >= NUM_CH reads 0.
//  Reset: counter=period=RESET_PERIOD, prescale=0, control=0, run=0, to=0, snap=0, readdata=0, irq=0.
//  Read latency 1 cycle: readdata registered from mux of current address every clk (no chipselect gating).
//  Tick: prescale counter counts 0..PRESCALE; tick when it equals PRESCALE and run=1; PRESCALE=0 -> tick every clk.
//   Prescale counter clears whenever run=0 or on PRESCALE write.
//  On tick: counter==0 -> reload period; else counter-1. Wrap only via reload; never below 0.
//  Period write (L or H): force_reload next cycle -> counter<=period, run<=0, prescale counter cleared.
//  run: set by CONTROL write with start=1; cleared by stop=1, force_reload, or counter==0 with cont=0.
//   start and stop in same write -> start wins. start in same cycle as force_reload -> start wins.
//  timeout event = counter==0 this cycle and !=0 previous cycle; sets to. STATUS write same cycle as event -> clear wins.
//  irq_vec[i] = to[i] & ito[i], combinational from registers; irq = |irq_vec.
//  Snapshot: SNAP_L write latches full counter into snap[CNT_W-1:0] atomically; SNAP_L/H reads return held value.
//  Channels fully independent; writes to one channel never affect another.
// STRUCTURE
//  Package timer_pkg: register offset localparams (REG_STATUS..REG_PRESCALE), control bit indices.
//  Sub-module timer_channel (one per channel, generate loop): counter, prescaler, run/to flags, snapshot, regs;
//   exposes per-channel write strobes in, read mux value and irq out. Top: address decode, read mux, readdata reg.
// TESTING
//  1 Reset, read ch0 PERIOD_L -> 49999 (0xC34F) one cycle after read; status=0, irq=0.
//  2 ch1 PERIOD_L=4,PERIOD_H=0, CONTROL=0x7 -> to set 5 clks after start; irq_vec=0b0010; counter reloads, run stays 1.
//  3 ch2 PERIOD=3, PRESCALE=2, CONTROL=0x5 (one-shot) -> counter steps every 3 clks; to at 0; run=0 after; irq only ch2.
//  4 ch0 running, SNAP_L write when counter=0x0001_2345 -> SNAP_L=0x2345, SNAP_H=0x0001 stable while counter moves.
//  5 STATUS write on same cycle as timeout event -> to stays 0; CONTROL=0xC -> run=1 (start wins).
//  6 Period write mid-count -> run=0, counter=new period next+1 cycle; reset_n pulse mid-count -> all reset values.

Source files
------------

// File: rtl/timer_pkg.sv
// Register map and bit positions shared by the timer top level and its channels.
// Each channel occupies eight word addresses; the channel index sits above them.
package timer_pkg;

  localparam int REG_AW = 3;

  localparam logic [REG_AW-1:0] REG_STATUS   = 3'd0;
  localparam logic [REG_AW-1:0] REG_CONTROL  = 3'd1;
  localparam logic [REG_AW-1:0] REG_PERIOD_L = 3'd2;
  localparam logic [REG_AW-1:0] REG_PERIOD_H = 3'd3;
  localparam logic [REG_AW-1:0] REG_SNAP_L   = 3'd4;
  localparam logic [REG_AW-1:0] REG_SNAP_H   = 3'd5;
  localparam logic [REG_AW-1:0] REG_PRESCALE = 3'd6;
  localparam logic [REG_AW-1:0] REG_RSVD     = 3'd7;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaled down-counter with period reload, run/timeout flags,
// atomic counter snapshot and its own register file and read mux.
module timer_channel
  import timer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr,
  input  logic [REG_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_irq
);

  localparam int HI_W = CNT_W - DATA_W;

  logic [CNT_W-1:0]      r_counter;
  logic [CNT_W-1:0]      r_period;
  logic [CNT_W-1:0]      r_snap;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_run;
  logic                  r_to;
  logic                  r_cont;
  logic                  r_ito;
  logic                  r_force_reload;
  logic                  r_zero_prev;

  logic w_wr_status, w_wr_control, w_wr_period_l, w_wr_period_h, w_wr_snap, w_wr_prescale;
  logic w_start, w_stop, w_zero, w_tick, w_event;

  assign w_wr_status   = i_wr & (i_addr == REG_STATUS);
  assign w_wr_control  = i_wr & (i_addr == REG_CONTROL);
  assign w_wr_period_l = i_wr & (i_addr == REG_PERIOD_L);
  assign w_wr_period_h = i_wr & (i_addr == REG_PERIOD_H);
  assign w_wr_snap     = i_wr & (i_addr == REG_SNAP_L);
  assign w_wr_prescale = i_wr & (i_addr == REG_PRESCALE);

  assign w_start = w_wr_control & i_wdata[CTRL_START];
  assign w_stop  = w_wr_control & i_wdata[CTRL_STOP];
  assign w_zero  = (r_counter == '0);
  assign w_tick  = r_run & (r_pcnt == r_prescale);
  assign w_event = w_zero & ~r_zero_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter      <= CNT_W'(RESET_PERIOD);
      r_period       <= CNT_W'(RESET_PERIOD);
      r_snap         <= '0;
      r_prescale     <= '0;
      r_pcnt         <= '0;
      r_run          <= 1'b0;
      r_to           <= 1'b0;
      r_cont         <= 1'b0;
      r_ito          <= 1'b0;
      r_force_reload <= 1'b0;
      r_zero_prev    <= (RESET_PERIOD == 0);
    end else begin
      r_force_reload <= w_wr_period_l | w_wr_period_h;
      r_zero_prev    <= w_zero;

      if (w_wr_period_l) r_period[DATA_W-1:0]     <= i_wdata;
      if (w_wr_period_h) r_period[CNT_W-1:DATA_W] <= i_wdata[HI_W-1:0];
      if (w_wr_prescale) r_prescale <= i_wdata[PRESCALE_W-1:0];
      if (w_wr_snap)     r_snap     <= r_counter;
      if (w_wr_control) begin
        r_cont <= i_wdata[CTRL_CONT];
        r_ito  <= i_wdata[CTRL_ITO];
      end

      if (!r_run || r_force_reload || w_wr_prescale || w_tick)
        r_pcnt <= '0;
      else
        r_pcnt <= r_pcnt + PRESCALE_W'(1);

      // A pending period write overrides any tick in the same cycle.
      if (r_force_reload)
        r_counter <= r_period;
      else if (w_tick)
        r_counter <= w_zero ? r_period : r_counter - CNT_W'(1);

      // One-shot mode stops on the tick that would otherwise wrap the counter.
      if (w_start)
        r_run <= 1'b1;
      else if (w_stop || r_force_reload || (w_tick && w_zero && !r_cont))
        r_run <= 1'b0;

      if (w_wr_status)
        r_to <= 1'b0;
      else if (w_event)
        r_to <= 1'b1;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      REG_STATUS: begin
        o_rdata[STAT_RUN] = r_run;
        o_rdata[STAT_TO]  = r_to;
      end
      REG_CONTROL: begin
        o_rdata[CTRL_CONT] = r_cont;
        o_rdata[CTRL_ITO]  = r_ito;
      end
      REG_PERIOD_L: o_rdata             = r_period[DATA_W-1:0];
      REG_PERIOD_H: o_rdata[HI_W-1:0]   = r_period[CNT_W-1:DATA_W];
      REG_SNAP_L:   o_rdata             = r_snap[DATA_W-1:0];
      REG_SNAP_H:   o_rdata[HI_W-1:0]   = r_snap[CNT_W-1:DATA_W];
      REG_PRESCALE: o_rdata[PRESCALE_W-1:0] = r_prescale;
      default:      o_rdata = '0;
    endcase
  end

  assign o_irq = r_to & r_ito;

endmodule

// File: rtl/avalon_multichannel_timer.sv
// N-channel interval timer on an Avalon-MM slave: channel decode, read-data mux
// with one-cycle registered read latency, and per-channel plus combined interrupts.
module avalon_multichannel_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [$clog2(NUM_CH)+2:0]    address,
  input  logic [DATA_W-1:0]            writedata,
  output logic [DATA_W-1:0]            readdata,
  output logic [NUM_CH-1:0]            irq_vec,
  output logic                         irq
);

  localparam int AW   = $clog2(NUM_CH) + 3;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   w_ch;
  logic              w_wr;
  logic [DATA_W-1:0] w_ch_rdata [NUM_CH];
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] r_readdata;

  generate
    if (NUM_CH > 1) begin : g_ch_dec
      assign w_ch = address[AW-1:REG_AW];
    end else begin : g_ch_single
      assign w_ch = 1'b0;
    end
  endgenerate

  assign w_wr = chipselect & ~write_n;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      timer_channel #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .PRESCALE_W  (PRESCALE_W),
        .RESET_PERIOD(RESET_PERIOD)
      ) u_channel (
        .clk    (clk),
        .reset_n(reset_n),
        .i_wr   (w_wr && (w_ch == CH_W'(gi))),
        .i_addr (address[REG_AW-1:0]),
        .i_wdata(writedata),
        .o_rdata(w_ch_rdata[gi]),
        .o_irq  (irq_vec[gi])
      );
    end
  endgenerate

  // Unpopulated channel indices fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CH_W'(i)) w_rd_mux = w_ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_avalon_multichannel_timer.sv
// Directed bench for the multichannel timer: bus writes/reads on negedges,
// expected values worked out by hand from the cycle timeline of each scenario.
module tb_avalon_multichannel_timer;
  import timer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int AW     = 5;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              chipselect = 1'b0;
  logic              write_n    = 1'b1;
  logic [AW-1:0]     address    = '0;
  logic [DATA_W-1:0] writedata  = '0;
  logic [DATA_W-1:0] readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_multichannel_timer #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .CNT_W       (32),
    .PRESCALE_W  (8),
    .RESET_PERIOD(49999)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .write_n   (write_n),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_vec   (irq_vec),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; the write is taken on the following posedge.
  task automatic bus_wr(input int ch, input logic [2:0] rg, input logic [15:0] d);
    address    = AW'(ch * 8 + int'(rg));
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("wr ch%0d reg%0d <= 0x%04h", ch, rg, d);
  endtask

  task automatic bus_rd_chk(input string tag, input int ch, input logic [2:0] rg,
                            input logic [15:0] exp);
    address    = AW'(ch * 8 + int'(rg));
    chipselect = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    $display("rd ch%0d reg%0d -> 0x%04h", ch, rg, readdata);
    check_eq(tag, {16'h0, readdata}, {16'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", {16'h0, readdata}, 32'h0);
    reset_n = 1'b1;
    bus_rd_chk("t1_period_l", 0, REG_PERIOD_L, 16'hC34F);
    bus_rd_chk("t1_period_h", 0, REG_PERIOD_H, 16'h0000);
    bus_rd_chk("t1_status",   0, REG_STATUS,   16'h0000);
    bus_rd_chk("t1_prescale", 2, REG_PRESCALE, 16'h0000);
    check_eq("t1_irq",     {31'h0, irq}, 32'h0);
    check_eq("t1_irq_vec", {28'h0, irq_vec}, 32'h0);
    bus_wr(1, REG_RSVD, 16'hFFFF);
    bus_rd_chk("t1_rsvd", 1, REG_RSVD, 16'h0000);

    // 2: ch1 continuous, period 4 -> timeout 5 clocks after start
    bus_wr(1, REG_PERIOD_L, 16'd4);
    bus_wr(1, REG_PERIOD_H, 16'd0);
    bus_wr(1, REG_CONTROL, 16'h0007);
    repeat (4) @(negedge clk);
    check_eq("t2_irqvec_early", {28'h0, irq_vec}, 32'h0);
    @(negedge clk);
    check_eq("t2_irqvec", {28'h0, irq_vec}, 32'h2);
    check_eq("t2_irq", {31'h0, irq}, 32'h1);
    bus_wr(1, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t2_reloaded", 1, REG_SNAP_L, 16'd4);
    bus_rd_chk("t2_status_run_to", 1, REG_STATUS, 16'h0003);
    bus_wr(1, REG_STATUS, 16'h0000);
    bus_rd_chk("t2_status_cleared", 1, REG_STATUS, 16'h0002);
    bus_wr(1, REG_CONTROL, 16'h0008);
    bus_rd_chk("t2_status_stopped", 1, REG_STATUS, 16'h0001);
    check_eq("t2_irq_masked", {28'h0, irq_vec}, 32'h0);
    bus_wr(1, REG_STATUS, 16'h0000);

    // 3: ch2 one-shot, period 3, prescale 2 -> one count per 3 clocks
    bus_wr(2, REG_PERIOD_L, 16'd3);
    bus_wr(2, REG_PERIOD_H, 16'd0);
    bus_wr(2, REG_PRESCALE, 16'd2);
    bus_wr(2, REG_CONTROL, 16'h0005);
    repeat (9) @(negedge clk);
    check_eq("t3_irqvec_early", {28'h0, irq_vec}, 32'h0);
    @(negedge clk);
    check_eq("t3_irqvec", {28'h0, irq_vec}, 32'h4);
    bus_wr(2, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t3_snap_zero", 2, REG_SNAP_L, 16'd0);
    bus_rd_chk("t3_status_oneshot", 2, REG_STATUS, 16'h0001);
    bus_wr(2, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t3_snap_reload", 2, REG_SNAP_L, 16'd3);
    bus_rd_chk("t3_prescale", 2, REG_PRESCALE, 16'd2);
    bus_wr(2, REG_STATUS, 16'h0000);
    check_eq("t3_irq_cleared", {31'h0, irq}, 32'h0);

    // 4: ch0 snapshot at counter 0x0001_2345
    bus_wr(0, REG_PERIOD_L, 16'h2346);
    bus_wr(0, REG_PERIOD_H, 16'h0001);
    bus_wr(0, REG_CONTROL, 16'h0006);
    @(negedge clk);
    bus_wr(0, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t4_snap_l", 0, REG_SNAP_L, 16'h2345);
    bus_rd_chk("t4_snap_h", 0, REG_SNAP_H, 16'h0001);
    bus_rd_chk("t4_snap_l_held", 0, REG_SNAP_L, 16'h2345);
    bus_wr(0, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t4_snap_l_moved", 0, REG_SNAP_L, 16'h2341);
    bus_wr(0, REG_CONTROL, 16'h0008);

    // 5: status clear coincident with timeout; start+stop together
    bus_wr(3, REG_PERIOD_L, 16'd2);
    bus_wr(3, REG_PERIOD_H, 16'd0);
    bus_wr(3, REG_CONTROL, 16'h0007);
    repeat (2) @(negedge clk);
    bus_wr(3, REG_STATUS, 16'h0000);
    check_eq("t5_clear_wins", {28'h0, irq_vec}, 32'h0);
    bus_rd_chk("t5_status", 3, REG_STATUS, 16'h0002);
    repeat (2) @(negedge clk);
    check_eq("t5_next_timeout", {28'h0, irq_vec}, 32'h8);
    bus_wr(3, REG_CONTROL, 16'h000C);
    bus_rd_chk("t5_start_wins", 3, REG_STATUS, 16'h0003);
    check_eq("t5_ito_off", {28'h0, irq_vec}, 32'h0);
    bus_wr(3, REG_CONTROL, 16'h0008);
    bus_rd_chk("t5_stop", 3, REG_STATUS, 16'h0001);
    bus_wr(3, REG_STATUS, 16'h0000);

    // 6: period write mid-count reloads one cycle later; then reset pulse
    bus_wr(0, REG_CONTROL, 16'h0006);
    bus_wr(0, REG_PERIOD_L, 16'h0010);
    bus_wr(0, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t6_snap_before_reload", 0, REG_SNAP_L, 16'h233D);
    bus_wr(0, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t6_snap_reload_l", 0, REG_SNAP_L, 16'h0010);
    bus_rd_chk("t6_snap_reload_h", 0, REG_SNAP_H, 16'h0001);
    bus_rd_chk("t6_status_stopped", 0, REG_STATUS, 16'h0000);
    bus_wr(0, REG_CONTROL, 16'h0006);
    bus_rd_chk("t6_period_l", 0, REG_PERIOD_L, 16'h0010);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_readdata", {16'h0, readdata}, 32'h0);
    check_eq("t6_rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd_chk("t6_rst_snap", 0, REG_SNAP_L, 16'h0000);
    bus_wr(0, REG_SNAP_L, 16'h0000);
    bus_rd_chk("t6_rst_counter", 0, REG_SNAP_L, 16'hC34F);
    bus_rd_chk("t6_rst_period", 0, REG_PERIOD_L, 16'hC34F);
    bus_rd_chk("t6_rst_status", 0, REG_STATUS, 16'h0000);
    bus_rd_chk("t6_rst_control", 0, REG_CONTROL, 16'h0000);
    bus_rd_chk("t6_rst_prescale", 2, REG_PRESCALE, 16'h0000);
    bus_rd_chk("t6_rst_period_h3", 3, REG_PERIOD_H, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
